spike_rate_monitor: RTL and testbench

//  Downstream consumer of the neuron core's 1-bit spike output. Detects spike onsets,

---
 rtl/spike_rate_monitor.sv | 164 ++++++++++++++++
 tb/tb_spike_rate_monitor.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_monitor.sv
// Spike onset rate monitor: counts spike onsets per fixed window (valid/ready readout)
// and measures the inter-spike interval between consecutive onsets.
module spike_rate_monitor #(
    parameter int WINDOW = 1000,
    parameter int WIN_W  = 10,
    parameter int CNT_W  = 8,
    parameter int ISI_W  = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             spike,
    output logic [CNT_W-1:0] rate_count,
    output logic             rate_valid,
    input  logic             rate_ready,
    output logic             overrun,
    output logic [ISI_W-1:0] isi,
    output logic             isi_valid
);

    typedef enum logic {W_IDLE, W_COUNT} win_state_t;
    typedef enum logic {NO_REF, TRACK} isi_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [ISI_W-1:0] GAP_MAX  = {ISI_W{1'b1}};
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

    win_state_t       win_state_reg, win_state_next;
    isi_state_t       isi_state_reg, isi_state_next;
    logic             spike_q_reg;
    logic [WIN_W-1:0] win_cnt_reg, win_cnt_next;
    logic [CNT_W-1:0] spk_cnt_reg, spk_cnt_next;
    logic [CNT_W-1:0] rate_count_reg, rate_count_next;
    logic             rate_valid_reg, rate_valid_next;
    logic             overrun_reg, overrun_next;
    logic [ISI_W-1:0] gap_reg, gap_next;
    logic [ISI_W-1:0] isi_reg, isi_next;
    logic             isi_valid_reg, isi_valid_next;

    logic             rise;
    logic             terminal;
    logic [CNT_W-1:0] spk_inc;

    assign rise     = spike & ~spike_q_reg;
    assign terminal = (win_state_reg == W_COUNT) && enable && (win_cnt_reg == WIN_LAST);
    // Saturating count including an onset that lands on the current cycle
    assign spk_inc  = (spk_cnt_reg == CNT_MAX) ? spk_cnt_reg
                                               : spk_cnt_reg + CNT_W'(rise);

    always_comb begin
        win_state_next  = win_state_reg;
        win_cnt_next    = win_cnt_reg;
        spk_cnt_next    = spk_cnt_reg;
        rate_count_next = rate_count_reg;
        rate_valid_next = rate_valid_reg;
        overrun_next    = overrun_reg;

        case (win_state_reg)
            W_IDLE: begin
                win_cnt_next = '0;
                spk_cnt_next = '0;
                if (enable)
                    win_state_next = W_COUNT;
            end
            W_COUNT: begin
                if (!enable) begin
                    // Partial window is discarded; the next window restarts from zero
                    win_state_next = W_IDLE;
                    win_cnt_next   = '0;
                    spk_cnt_next   = '0;
                end else if (terminal) begin
                    win_cnt_next = '0;
                    spk_cnt_next = '0;
                end else begin
                    win_cnt_next = win_cnt_reg + WIN_W'(1);
                    spk_cnt_next = spk_inc;
                end
            end
            default: begin
                win_state_next = W_IDLE;
                win_cnt_next   = '0;
                spk_cnt_next   = '0;
            end
        endcase

        // A result may replace one that is being accepted in the same cycle
        if (terminal) begin
            if (!rate_valid_reg || rate_ready) begin
                rate_count_next = spk_inc;
                rate_valid_next = 1'b1;
            end else begin
                overrun_next = 1'b1;
            end
        end else if (rate_valid_reg && rate_ready) begin
            rate_valid_next = 1'b0;
        end
    end

    always_comb begin
        isi_state_next = isi_state_reg;
        gap_next       = gap_reg;
        isi_next       = isi_reg;
        isi_valid_next = 1'b0;

        if (!enable) begin
            isi_state_next = NO_REF;
            gap_next       = '0;
        end else begin
            case (isi_state_reg)
                NO_REF: begin
                    if (rise) begin
                        isi_state_next = TRACK;
                        gap_next       = ISI_W'(1);
                    end
                end
                TRACK: begin
                    if (rise) begin
                        isi_next       = gap_reg;
                        isi_valid_next = 1'b1;
                        gap_next       = ISI_W'(1);
                    end else if (gap_reg != GAP_MAX) begin
                        gap_next = gap_reg + ISI_W'(1);
                    end
                end
                default: isi_state_next = NO_REF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            spike_q_reg    <= 1'b0;
            win_state_reg  <= W_IDLE;
            win_cnt_reg    <= '0;
            spk_cnt_reg    <= '0;
            rate_count_reg <= '0;
            rate_valid_reg <= 1'b0;
            overrun_reg    <= 1'b0;
            isi_state_reg  <= NO_REF;
            gap_reg        <= '0;
            isi_reg        <= '0;
            isi_valid_reg  <= 1'b0;
        end else begin
            spike_q_reg    <= spike;
            win_state_reg  <= win_state_next;
            win_cnt_reg    <= win_cnt_next;
            spk_cnt_reg    <= spk_cnt_next;
            rate_count_reg <= rate_count_next;
            rate_valid_reg <= rate_valid_next;
            overrun_reg    <= overrun_next;
            isi_state_reg  <= isi_state_next;
            gap_reg        <= gap_next;
            isi_reg        <= isi_next;
            isi_valid_reg  <= isi_valid_next;
        end
    end

    assign rate_count = rate_count_reg;
    assign rate_valid = rate_valid_reg;
    assign overrun    = overrun_reg;
    assign isi        = isi_reg;
    assign isi_valid  = isi_valid_reg;

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Directed-vector bench for spike_rate_monitor; a second instance with a 3-bit count
// exercises count saturation.
module tb_spike_rate_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       spike = 1'b0;
    logic       rate_ready = 1'b0;

    logic [3:0] rate_count;
    logic       rate_valid, overrun, isi_valid;
    logic [5:0] isi;

    logic [2:0] rate_count_b;
    logic       rate_valid_b, overrun_b, isi_valid_b;
    logic [5:0] isi_b;

    int n_vec = 0;
    int n_err = 0;
    logic any_isi;

    always #5 clk = ~clk;

    spike_rate_monitor #(.WINDOW(16), .WIN_W(5), .CNT_W(4), .ISI_W(6)) dut (
        .clk(clk), .reset(reset), .enable(enable), .spike(spike),
        .rate_count(rate_count), .rate_valid(rate_valid), .rate_ready(rate_ready),
        .overrun(overrun), .isi(isi), .isi_valid(isi_valid)
    );

    spike_rate_monitor #(.WINDOW(16), .WIN_W(5), .CNT_W(3), .ISI_W(6)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .spike(spike),
        .rate_count(rate_count_b), .rate_valid(rate_valid_b), .rate_ready(rate_ready),
        .overrun(overrun_b), .isi(isi_b), .isi_valid(isi_valid_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the window FSM counting with window cycle 0 processed on the next edge
    task automatic start_test();
        reset = 1'b1; enable = 1'b0; spike = 1'b0; rate_ready = 1'b0;
        step();
        step();
        reset = 1'b0; enable = 1'b1;
        step();
    endtask

    initial begin
        // Reset state
        step();
        chk("rst rate_count", 32'(rate_count), 0);
        chk("rst rate_valid", 32'(rate_valid), 0);
        chk("rst overrun", 32'(overrun), 0);
        chk("rst isi", 32'(isi), 0);
        chk("rst isi_valid", 32'(isi_valid), 0);

        // 1: onsets at window cycles 2, 7, 15
        start_test();
        for (int c = 0; c < 16; c++) begin
            spike = (c == 2 || c == 7 || c == 15);
            step();
            if (c == 2)  chk("t1 first onset no isi", 32'(isi_valid), 0);
            if (c == 7) begin
                chk("t1 isi_valid a", 32'(isi_valid), 1);
                chk("t1 isi a", 32'(isi), 5);
            end
            if (c == 8)  chk("t1 isi pulse one cycle", 32'(isi_valid), 0);
            if (c == 14) chk("t1 valid before terminal", 32'(rate_valid), 0);
            if (c == 15) begin
                chk("t1 isi_valid b", 32'(isi_valid), 1);
                chk("t1 isi b", 32'(isi), 8);
                chk("t1 rate_valid", 32'(rate_valid), 1);
                chk("t1 rate_count", 32'(rate_count), 3);
            end
        end

        // 2: spike held high six cycles counts once
        start_test();
        any_isi = 1'b0;
        for (int c = 0; c < 16; c++) begin
            spike = (c >= 3 && c <= 8);
            step();
            if (isi_valid) any_isi = 1'b1;
        end
        chk("t2 no isi_valid", 32'(any_isi), 0);
        chk("t2 rate_count", 32'(rate_count), 1);
        chk("t2 rate_valid", 32'(rate_valid), 1);

        // 3: result held across two windows with ready low
        start_test();
        for (int t = 0; t < 32; t++) begin
            spike = (t == 4 || t == 9 || t == 21);
            step();
            if (t == 9) chk("t3 isi a", 32'(isi), 5);
            if (t == 15) begin
                chk("t3 w1 count", 32'(rate_count), 2);
                chk("t3 w1 valid", 32'(rate_valid), 1);
                chk("t3 w1 overrun", 32'(overrun), 0);
            end
            if (t == 21) begin
                chk("t3 isi_valid across window", 32'(isi_valid), 1);
                chk("t3 isi across window", 32'(isi), 12);
            end
            if (t == 31) begin
                chk("t3 w2 count retained", 32'(rate_count), 2);
                chk("t3 w2 valid", 32'(rate_valid), 1);
                chk("t3 w2 overrun", 32'(overrun), 1);
            end
        end
        spike = 1'b0;
        rate_ready = 1'b1;
        step();
        chk("t3 accept valid drops", 32'(rate_valid), 0);
        chk("t3 overrun sticky", 32'(overrun), 1);
        rate_ready = 1'b0;

        // 4: eight onsets in one window; 3-bit count saturates at 7
        start_test();
        for (int c = 0; c < 16; c++) begin
            spike = (c % 2 == 0);
            step();
            if (c == 2) begin
                chk("t4 isi_valid", 32'(isi_valid), 1);
                chk("t4 isi min", 32'(isi), 2);
            end
            if (c == 15) begin
                chk("t4 count 4bit", 32'(rate_count), 8);
                chk("t4 count 3bit sat", 32'(rate_count_b), 7);
                chk("t4 valid 3bit", 32'(rate_valid_b), 1);
            end
        end

        // 5: saturated isi; ready on terminal cycle loads new count
        start_test();
        for (int t = 0; t < 80; t++) begin
            spike = (t == 1 || t == 71);
            rate_ready = (t >= 31);
            step();
            if (t == 15) begin
                chk("t5 w1 count", 32'(rate_count), 1);
                chk("t5 w1 valid", 32'(rate_valid), 1);
            end
            if (t == 31) begin
                chk("t5 load on accept count", 32'(rate_count), 0);
                chk("t5 load on accept valid", 32'(rate_valid), 1);
                chk("t5 load on accept overrun", 32'(overrun), 0);
            end
            if (t == 32) chk("t5 valid drops", 32'(rate_valid), 0);
            if (t == 71) begin
                chk("t5 isi_valid sat", 32'(isi_valid), 1);
                chk("t5 isi saturated", 32'(isi), 63);
            end
            if (t == 79) begin
                chk("t5 w5 count", 32'(rate_count), 1);
                chk("t5 overrun clear", 32'(overrun), 0);
            end
        end
        rate_ready = 1'b0;

        // 6: reset mid-window, then enable drop mid-window
        start_test();
        for (int t = 0; t < 21; t++) begin
            spike = (t == 3 || t == 18);
            step();
            if (t == 15) chk("t6 valid pre-reset", 32'(rate_valid), 1);
            if (t == 18) chk("t6 isi pre-reset", 32'(isi), 15);
        end
        reset = 1'b1;
        spike = 1'b0;
        step();
        chk("t6 reset rate_count", 32'(rate_count), 0);
        chk("t6 reset rate_valid", 32'(rate_valid), 0);
        chk("t6 reset overrun", 32'(overrun), 0);
        chk("t6 reset isi", 32'(isi), 0);
        chk("t6 reset isi_valid", 32'(isi_valid), 0);
        reset = 1'b0;
        step();
        for (int c = 0; c < 6; c++) begin
            spike = (c == 1 || c == 4);
            step();
            if (c == 4) chk("t6 isi partial", 32'(isi), 3);
        end
        spike = 1'b0;
        enable = 1'b0;
        step();
        step();
        enable = 1'b1;
        step();
        for (int c = 0; c < 16; c++) begin
            spike = (c == 10);
            step();
            if (c == 10) begin
                chk("t6 no isi after disable", 32'(isi_valid), 0);
                chk("t6 isi holds", 32'(isi), 3);
            end
            if (c == 14) chk("t6 no early result", 32'(rate_valid), 0);
            if (c == 15) begin
                chk("t6 fresh window count", 32'(rate_count), 1);
                chk("t6 fresh window valid", 32'(rate_valid), 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
